hud_score_digits: RTL and testbench

Upstream HUD stage that owns the player score and renders it as three on-screen digits for the HUD priority mux. It accumulates BCD point increments through a valid/ready handshake, saturates at 999, and latches the displayed value once per frame. Per pixel, it produces one drawing request and one RGB332 colour per digit slot: index 0 is hundreds (leftmost), index 2 is units. Both outputs are registered and aligned to the mux's inputs.

---
 rtl/hud_pkg.sv | 30 +++
 rtl/digit_font_rom.sv | 34 +++
 rtl/hud_score_digits.sv | 175 +++++++++++++++++
 tb/tb_hud_score_digits.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared types and helpers for the HUD score block: BCD digit/score types,
// adder FSM states, glyph geometry and the BCD digit-step arithmetic.
package hud_pkg;

  typedef logic [3:0] bcd_t;
  // Index 2 is hundreds, index 0 is units.
  typedef bcd_t [2:0] score_t;

  typedef enum logic [1:0] {IDLE, D0, D1, D2} add_state_t;

  localparam logic [7:0] COLOR_TRANSPARENT = 8'h00;
  localparam int DIGIT_W = 8;
  localparam int DIGIT_H = 16;

  // Out-of-range BCD nibbles are treated as 9.
  function automatic bcd_t clamp_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // One decimal digit add; result is {carry_out, digit}.
  function automatic logic [4:0] bcd_step(input bcd_t a, input bcd_t b, input logic cin);
    logic [4:0] s;
    logic [4:0] t;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    t = s - 5'd10;
    if (s > 5'd9) return {1'b1, t[3:0]};
    return s;
  endfunction

endpackage

// File: rtl/digit_font_rom.sv
// Combinational 0-9 glyph bitmap. Glyphs are drawn on an 8x8 grid and doubled
// vertically to fill the 8x16 digit box; column 0 is the leftmost pixel.
module digit_font_rom
  import hud_pkg::*;
(
  input  bcd_t       digit,
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic       pixel
);

  logic [63:0] glyph;
  logic [7:0]  rowBits;

  // Glyph lookup; top row sits in the most significant byte.
  always_comb begin
    case (digit)
      4'd0:    glyph = 64'h3C666E7666663C00;
      4'd1:    glyph = 64'h183818181818_7E00;
      4'd2:    glyph = 64'h3C66060C30607E00;
      4'd3:    glyph = 64'h3C66061C06663C00;
      4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph = 64'h7E607C0606663C00;
      4'd6:    glyph = 64'h3C607C6666663C00;
      4'd7:    glyph = 64'h7E060C1818181800;
      4'd8:    glyph = 64'h3C66663C66663C00;
      4'd9:    glyph = 64'h3C66663E060C3800;
      default: glyph = 64'h0;
    endcase
    rowBits = glyph[{3'd7 - row[3:1], 3'b000} +: 8];
    pixel   = rowBits[3'd7 - col];
  end

endmodule

// File: rtl/hud_score_digits.sv
// Player score owner: BCD accumulator with saturation at 999, per-frame display
// shadow, and a two-stage renderer producing per-digit draw requests and colours.
module hud_score_digits
  import hud_pkg::*;
#(
  parameter logic [10:0] ORIGIN_X    = 11'd560,
  parameter logic [10:0] ORIGIN_Y    = 11'd8,
  parameter int          DIGIT_GAP   = 2,
  parameter logic [7:0]  SCORE_COLOR = 8'hFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startOfFrame,
  input  logic [10:0]     pixelX,
  input  logic [10:0]     pixelY,
  input  logic            addValid,
  input  logic [7:0]      addBCD,
  output logic            addReady,
  input  logic            clearScore,
  output logic [11:0]     scoreBCD,
  output logic            saturated,
  output logic [2:0]      scoreDrawingRequest,
  output logic [2:0][7:0] scoreRGB
);

  localparam logic [10:0] BOX_X [3] = '{
    ORIGIN_X,
    ORIGIN_X + 11'(DIGIT_W + DIGIT_GAP),
    ORIGIN_X + 11'(2 * (DIGIT_W + DIGIT_GAP))
  };

  add_state_t state;
  score_t     score;
  score_t     shadow;
  bcd_t       opLo, opHi, sumLo, sumMid;
  logic       carry;
  logic [4:0] step2;

  assign scoreBCD = score;
  assign step2    = bcd_step(score[2], 4'd0, carry);

  // Adder FSM: one digit per cycle, write-back only at the end of D2; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addReady  <= 1'b1;
      score     <= '0;
      saturated <= 1'b0;
      opLo      <= '0;
      opHi      <= '0;
      sumLo     <= '0;
      sumMid    <= '0;
      carry     <= 1'b0;
    end else if (clearScore) begin
      state     <= IDLE;
      addReady  <= 1'b1;
      score     <= '0;
      saturated <= 1'b0;
    end else begin
      case (state)
        IDLE: if (addValid) begin
          opLo     <= clamp_bcd(addBCD[3:0]);
          opHi     <= clamp_bcd(addBCD[7:4]);
          addReady <= 1'b0;
          state    <= D0;
        end
        D0: begin
          {carry, sumLo} <= bcd_step(score[0], opLo, 1'b0);
          state          <= D1;
        end
        D1: begin
          {carry, sumMid} <= bcd_step(score[1], opHi, carry);
          state           <= D2;
        end
        D2: begin
          // Once saturated, accepted increments are silently dropped.
          if (!saturated) begin
            if (step2[4]) begin
              score     <= {4'd9, 4'd9, 4'd9};
              saturated <= 1'b1;
            end else begin
              score <= {step2[3:0], sumMid, sumLo};
            end
          end
          addReady <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display shadow: frozen for the whole frame to avoid tearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow <= '0;
    else if (startOfFrame) shadow <= score;
  end

  logic [2:0] suppress;
  logic       inRows;
  logic       hit;
  logic [1:0] idx;
  logic [2:0] lx;
  logic [3:0] ly;
  bcd_t       dig;

  // Box hit test with leading-zero suppression folded in.
  always_comb begin
    suppress[0] = (shadow[2] == 4'd0);
    suppress[1] = (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
    suppress[2] = 1'b0;
    inRows = (pixelY >= ORIGIN_Y) && (pixelY <= ORIGIN_Y + 11'(DIGIT_H - 1));
    hit = 1'b0;
    idx = 2'd0;
    lx  = 3'd0;
    ly  = pixelY[3:0] - ORIGIN_Y[3:0];
    dig = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (inRows && !suppress[k] && (pixelX >= BOX_X[k]) &&
          (pixelX <= BOX_X[k] + 11'(DIGIT_W - 1))) begin
        hit = 1'b1;
        idx = 2'(k);
        lx  = pixelX[2:0] - BOX_X[k][2:0];
        dig = shadow[2 - k];
      end
    end
  end

  logic       s1Hit;
  logic [1:0] s1Idx;
  logic [2:0] s1Lx;
  logic [3:0] s1Ly;
  bcd_t       s1Digit;
  logic       fontBit;

  // Render stage 1: register box hit, slot, local coordinates and digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Hit   <= 1'b0;
      s1Idx   <= 2'd0;
      s1Lx    <= 3'd0;
      s1Ly    <= 4'd0;
      s1Digit <= 4'd0;
    end else begin
      s1Hit   <= hit;
      s1Idx   <= idx;
      s1Lx    <= lx;
      s1Ly    <= ly;
      s1Digit <= dig;
    end
  end

  digit_font_rom u_font (
    .digit (s1Digit),
    .row   (s1Ly),
    .col   (s1Lx),
    .pixel (fontBit)
  );

  // Render stage 2: register font bit into per-slot request and colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scoreDrawingRequest <= '0;
      scoreRGB            <= {3{COLOR_TRANSPARENT}};
    end else begin
      scoreDrawingRequest <= '0;
      scoreRGB            <= {3{COLOR_TRANSPARENT}};
      if (s1Hit && fontBit) begin
        scoreDrawingRequest[s1Idx] <= 1'b1;
        scoreRGB[s1Idx]            <= SCORE_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_hud_score_digits.sv
// Directed bench for hud_score_digits: adder timing, saturation, clamping,
// clear priority, async reset, and rendered glyph pixels per frame.
module tb_hud_score_digits;

  logic            clk = 1'b0;
  logic            reset;
  logic            startOfFrame;
  logic [10:0]     pixelX, pixelY;
  logic            addValid;
  logic [7:0]      addBCD;
  logic            addReady;
  logic            clearScore;
  logic [11:0]     scoreBCD;
  logic            saturated;
  logic [2:0]      scoreDrawingRequest;
  logic [2:0][7:0] scoreRGB;

  int checks = 0;
  int errors = 0;
  logic [7:0] font [10][8];

  always #5 clk = ~clk;

  hud_score_digits dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .addValid            (addValid),
    .addBCD              (addBCD),
    .addReady            (addReady),
    .clearScore          (clearScore),
    .scoreBCD            (scoreBCD),
    .saturated           (saturated),
    .scoreDrawingRequest (scoreDrawingRequest),
    .scoreRGB            (scoreRGB)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [2:0] exp_req(input int x, input int y, input logic [11:0] d);
    logic [2:0] r;
    logic [3:0] dg;
    logic [7:0] rowv;
    logic vis;
    int x0;
    r = 3'b000;
    for (int k = 0; k < 3; k++) begin
      x0 = 560 + k * 10;
      if (x >= x0 && x <= x0 + 7 && y >= 8 && y <= 23) begin
        dg  = (k == 0) ? d[11:8] : (k == 1) ? d[7:4] : d[3:0];
        vis = (k == 2) || (k == 1 && d[11:4] != 8'h00) || (k == 0 && d[11:8] != 4'h0);
        rowv = font[dg][(y - 8) / 2];
        if (vis && rowv[7 - (x - x0)]) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic do_add(input logic [7:0] v, input logic [11:0] oldv,
                        input logic [11:0] newv, input logic expSat);
    int n;
    n = 0;
    while (!addReady && n < 20) begin tick; n++; end
    checks++;
    if (addReady !== 1'b1) begin errors++; $display("FAIL add_wait_ready: addReady=%b want 1", addReady); end
    addValid = 1'b1; addBCD = v;
    tick;
    addValid = 1'b0;
    checks++;
    if (addReady !== 1'b0) begin errors++; $display("FAIL add_busy t+1 (%h): addReady=%b want 0", v, addReady); end
    tick; tick;
    checks++;
    if (scoreBCD !== oldv || addReady !== 1'b0) begin
      errors++; $display("FAIL add_no_partial t+3 (%h): score=%h ready=%b want %h/0", v, scoreBCD, addReady, oldv);
    end
    tick;
    checks++;
    if (scoreBCD !== newv) begin errors++; $display("FAIL add_result t+4 (%h): score=%h want %h", v, scoreBCD, newv); end
    checks++;
    if (saturated !== expSat || addReady !== 1'b1) begin
      errors++; $display("FAIL add_flags (%h): sat=%b ready=%b want %b/1", v, saturated, addReady, expSat);
    end
  endtask

  task automatic do_clear;
    clearScore = 1'b1;
    tick;
    clearScore = 1'b0;
    checks++;
    if (scoreBCD !== 12'h000 || saturated !== 1'b0 || addReady !== 1'b1) begin
      errors++; $display("FAIL clear: score=%h sat=%b ready=%b want 000/0/1", scoreBCD, saturated, addReady);
    end
  endtask

  task automatic pulse_sof;
    startOfFrame = 1'b1;
    tick;
    startOfFrame = 1'b0;
  endtask

  task automatic sweep(input logic [11:0] disp, input string tag);
    logic [2:0]      prevReq, curReq;
    logic [2:0][7:0] er;
    int expLit, gotLit, low01;
    expLit = 0; gotLit = 0; low01 = 0;
    prevReq = 3'b000;
    for (int y = 6; y <= 26; y++) begin
      for (int x = 556; x <= 591; x++) begin
        pixelX = 11'(x); pixelY = 11'(y);
        curReq = (y == 26) ? 3'b000 : exp_req(x, y, disp);
        tick;
        // Outputs now belong to the pixel presented one iteration earlier.
        for (int k = 0; k < 3; k++) er[k] = prevReq[k] ? 8'hFC : 8'h00;
        checks++;
        if (scoreDrawingRequest !== prevReq || scoreRGB !== er) begin
          errors++;
          $display("FAIL %s pixel: x=%0d y=%0d req=%b rgb=%h want %b/%h", tag, x, y,
                   scoreDrawingRequest, scoreRGB, prevReq, er);
        end
        if (scoreDrawingRequest[2]) gotLit++;
        if (scoreDrawingRequest[1:0] != 2'b00) low01++;
        if (prevReq[2]) expLit++;
        prevReq = curReq;
      end
    end
    pixelX = 11'd0; pixelY = 11'd0;
    tick;
    checks++;
    if (gotLit !== expLit || expLit == 0) begin
      errors++; $display("FAIL %s lit_count: got %0d want %0d (nonzero)", tag, gotLit, expLit);
    end
    if (disp[11:4] == 8'h00) begin
      checks++;
      if (low01 !== 0) begin errors++; $display("FAIL %s suppressed_slots: %0d hits want 0", tag, low01); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; startOfFrame = 1'b0; addValid = 1'b0; addBCD = 8'h00;
    clearScore = 1'b0; pixelX = 11'd0; pixelY = 11'd0;
    tick; tick;
    reset = 1'b0;
    tick;
    checks++;
    if (addReady !== 1'b1 || scoreBCD !== 12'h000 || saturated !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b score=%h sat=%b want 1/000/0", addReady, scoreBCD, saturated);
    end
    checks++;
    if (scoreDrawingRequest !== 3'b000 || scoreRGB !== 24'h000000) begin
      errors++; $display("FAIL reset_render: req=%b rgb=%h want 000/000000", scoreDrawingRequest, scoreRGB);
    end
  endtask

  task automatic test_accumulate;
    do_add(8'h45, 12'h000, 12'h045, 1'b0);
    do_add(8'h45, 12'h045, 12'h090, 1'b0);
    do_add(8'h45, 12'h090, 12'h135, 1'b0);
  endtask

  task automatic test_saturate;
    do_clear;
    for (int i = 0; i < 10; i++) do_add(8'h99, to_bcd(99 * i), to_bcd(99 * (i + 1)), 1'b0);
    do_add(8'h25, 12'h990, 12'h999, 1'b1);
    do_add(8'h01, 12'h999, 12'h999, 1'b1);
    do_clear;
  endtask

  task automatic test_clamp;
    do_add(8'h3A, 12'h000, 12'h039, 1'b0);
    do_add(8'hFF, 12'h039, 12'h138, 1'b0);
    do_add(8'hF0, 12'h138, 12'h228, 1'b0);
    do_clear;
  endtask

  task automatic test_clear_inflight;
    do_add(8'h50, 12'h000, 12'h050, 1'b0);
    addValid = 1'b1; addBCD = 8'h12;
    tick;                       // D0
    addValid = 1'b0;
    tick;                       // D1
    clearScore = 1'b1;
    tick;
    clearScore = 1'b0;
    checks++;
    if (scoreBCD !== 12'h000 || addReady !== 1'b1 || saturated !== 1'b0) begin
      errors++; $display("FAIL clear_in_D1: score=%h ready=%b sat=%b want 000/1/0", scoreBCD, addReady, saturated);
    end
    tick; tick; tick; tick;
    checks++;
    if (scoreBCD !== 12'h000 || addReady !== 1'b1) begin
      errors++; $display("FAIL clear_dropped_add: score=%h ready=%b want 000/1", scoreBCD, addReady);
    end
    addValid = 1'b1; clearScore = 1'b1; addBCD = 8'h33;
    tick;
    addValid = 1'b0; clearScore = 1'b0;
    checks++;
    if (addReady !== 1'b1) begin errors++; $display("FAIL clear_same_cycle_ready: ready=%b want 1", addReady); end
    tick; tick; tick; tick;
    checks++;
    if (scoreBCD !== 12'h000) begin errors++; $display("FAIL clear_same_cycle_score: score=%h want 000", scoreBCD); end
  endtask

  task automatic test_async_reset;
    do_add(8'h77, 12'h000, 12'h077, 1'b0);
    pulse_sof;
    addValid = 1'b1; addBCD = 8'h11;
    tick;
    addValid = 1'b0;
    tick;                       // D1
    #2 reset = 1'b1;
    #1;
    checks++;
    if (scoreBCD !== 12'h000 || addReady !== 1'b1 || saturated !== 1'b0) begin
      errors++; $display("FAIL async_reset: score=%h ready=%b sat=%b want 000/1/0", scoreBCD, addReady, saturated);
    end
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (dut.shadow !== 12'h000) begin errors++; $display("FAIL async_reset_shadow: shadow=%h want 000", dut.shadow); end
  endtask

  task automatic test_render;
    do_clear;
    do_add(8'h07, 12'h000, 12'h007, 1'b0);
    pulse_sof;
    pixelX = 11'd0; pixelY = 11'd0;
    tick; tick;
    // Glyph 7 top row is 0x7E, so column 1 of box 2 is lit.
    pixelX = 11'd581; pixelY = 11'd8;
    tick;
    pixelX = 11'd0; pixelY = 11'd0;
    checks++;
    if (scoreDrawingRequest !== 3'b000) begin
      errors++; $display("FAIL latency_early: req=%b want 000", scoreDrawingRequest);
    end
    tick;
    checks++;
    if (scoreDrawingRequest !== 3'b100 || scoreRGB[2] !== 8'hFC) begin
      errors++; $display("FAIL latency_hit: req=%b rgb2=%h want 100/fc", scoreDrawingRequest, scoreRGB[2]);
    end
    tick;
    checks++;
    if (scoreDrawingRequest !== 3'b000) begin
      errors++; $display("FAIL latency_after: req=%b want 000", scoreDrawingRequest);
    end
    sweep(12'h007, "frame007");
  endtask

  task automatic test_midframe;
    do_add(8'h99, 12'h007, 12'h106, 1'b0);
    sweep(12'h007, "midframe_hold");
    pulse_sof;
    sweep(12'h106, "frame106");
  endtask

  initial begin
    font[0] = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
    font[1] = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
    font[2] = '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00};
    font[3] = '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00};
    font[4] = '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00};
    font[5] = '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00};
    font[6] = '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00};
    font[7] = '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00};
    font[8] = '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00};
    font[9] = '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00};

    test_reset;
    test_accumulate;
    test_saturate;
    test_clamp;
    test_clear_inflight;
    test_async_reset;
    test_render;
    test_midframe;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
